// File: rtl/fir_tap_feeder_if.sv
// rtl/fir_tap_feeder_if.sv - sample stream and coefficient write bus for fir_tap_feeder
interface fir_tap_feeder_if #(
  parameter int DATA_WIDTH = 13,
  parameter int TAPS       = 8,
  localparam int CW        = $clog2(TAPS)
);

  logic signed [DATA_WIDTH-1:0] DIN;
  logic                         VIN;
  logic                         RDY_IN;
  logic                         COEF_WE;
  logic        [CW-1:0]         COEF_ADDR;
  logic signed [DATA_WIDTH-1:0] COEF_DATA;
  logic                         COEF_COMMIT;

  modport master (
    output DIN,
    output VIN,
    input  RDY_IN,
    output COEF_WE,
    output COEF_ADDR,
    output COEF_DATA,
    output COEF_COMMIT
  );

  modport slave (
    input  DIN,
    input  VIN,
    output RDY_IN,
    input  COEF_WE,
    input  COEF_ADDR,
    input  COEF_DATA,
    input  COEF_COMMIT
  );

endinterface

// File: rtl/fir_tap_feeder.sv
// rtl/fir_tap_feeder.sv - sample delay line and double-buffered coefficient bank feeding the FIR MAC
module fir_tap_feeder #(
  parameter int DATA_WIDTH = 13,
  parameter int TAPS       = 8,
  localparam int CW        = $clog2(TAPS),
  localparam int FW        = $clog2(TAPS+1)
) (
  input  logic                         CLK,
  input  logic                         RST_n,
  fir_tap_feeder_if.slave              bus,
  input  logic                         FLUSH,
  output logic signed [DATA_WIDTH-1:0] tp_w [0:TAPS-1],
  output logic signed [DATA_WIDTH-1:0] H    [0:TAPS-1],
  output logic                         VWIN,
  output logic        [FW-1:0]         FILL_CNT
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic signed [DATA_WIDTH-1:0] r_tp          [0:TAPS-1];
  logic signed [DATA_WIDTH-1:0] r_h           [0:TAPS-1];
  logic signed [DATA_WIDTH-1:0] r_shadow      [0:TAPS-1];
  logic signed [DATA_WIDTH-1:0] w_shadow_next [0:TAPS-1];
  logic        [FW-1:0]         r_fill_cnt;
  logic        [FW-1:0]         w_fill_next;
  logic                         r_vwin;
  logic                         w_rdy;
  logic                         w_accept;
  logic                         w_fill_full;

  // Shadow with this cycle's write applied, so a commit sees a same-cycle write.
  // Addresses at or above TAPS match no entry and are dropped.
  always_comb begin
    for (int i = 0; i < TAPS; i++) begin
      w_shadow_next[i] = r_shadow[i];
      if (bus.COEF_WE && (bus.COEF_ADDR == CW'(i))) begin
        w_shadow_next[i] = bus.COEF_DATA;
      end
    end
  end

  always_comb begin
    w_accept    = bus.VIN && w_rdy;
    w_fill_full = (r_fill_cnt == FW'(TAPS));
    w_fill_next = w_fill_full ? r_fill_cnt : (r_fill_cnt + FW'(1));
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.COEF_COMMIT) begin
          w_state_next = S_FILL;
        end
      end
      S_FILL: begin
        if (FLUSH) begin
          w_state_next = S_FILL;
        end else if (w_accept && (w_fill_next == FW'(TAPS))) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (FLUSH) begin
          w_state_next = S_FILL;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Commit and flush cycles refuse samples so a window never straddles two H versions.
  always_comb begin
    w_rdy = (r_state != S_IDLE) && !FLUSH && !bus.COEF_COMMIT;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < TAPS; i++) begin
        r_tp[i] <= '0;
      end
      r_fill_cnt <= '0;
      r_vwin     <= 1'b0;
    end else begin
      r_vwin <= w_accept && (w_fill_next == FW'(TAPS));
      if (FLUSH) begin
        for (int i = 0; i < TAPS; i++) begin
          r_tp[i] <= '0;
        end
        r_fill_cnt <= '0;
      end else if (w_accept) begin
        r_tp[0] <= bus.DIN;
        for (int i = 1; i < TAPS; i++) begin
          r_tp[i] <= r_tp[i-1];
        end
        r_fill_cnt <= w_fill_next;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < TAPS; i++) begin
        r_shadow[i] <= '0;
        r_h[i]      <= '0;
      end
    end else begin
      for (int i = 0; i < TAPS; i++) begin
        r_shadow[i] <= w_shadow_next[i];
        if (bus.COEF_COMMIT) begin
          r_h[i] <= w_shadow_next[i];
        end
      end
    end
  end

  assign bus.RDY_IN = w_rdy;
  assign tp_w       = r_tp;
  assign H          = r_h;
  assign VWIN       = r_vwin;
  assign FILL_CNT   = r_fill_cnt;

endmodule

// File: tb/tb_fir_tap_feeder.sv
// tb/tb_fir_tap_feeder.sv - directed self-checking bench for fir_tap_feeder
module tb_fir_tap_feeder;

  localparam int DATA_WIDTH = 13;
  localparam int TAPS       = 8;
  localparam int FW         = $clog2(TAPS+1);

  logic                         CLK;
  logic                         RST_n;
  logic                         FLUSH;
  logic signed [DATA_WIDTH-1:0] tp_w [0:TAPS-1];
  logic signed [DATA_WIDTH-1:0] H    [0:TAPS-1];
  logic                         VWIN;
  logic        [FW-1:0]         FILL_CNT;

  int n_checks;
  int n_errors;

  fir_tap_feeder_if #(.DATA_WIDTH(DATA_WIDTH), .TAPS(TAPS)) u_if ();

  fir_tap_feeder #(.DATA_WIDTH(DATA_WIDTH), .TAPS(TAPS)) u_dut (
    .CLK      (CLK),
    .RST_n    (RST_n),
    .bus      (u_if),
    .FLUSH    (FLUSH),
    .tp_w     (tp_w),
    .H        (H),
    .VWIN     (VWIN),
    .FILL_CNT (FILL_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One accepted sample; returns just after the following falling edge.
  task automatic push(input int d);
    u_if.VIN = 1'b1;
    u_if.DIN = DATA_WIDTH'(d);
    @(negedge CLK);
    u_if.VIN = 1'b0;
  endtask

  task automatic idle_cycle();
    u_if.VIN = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    RST_n             = 1'b0;
    FLUSH             = 1'b0;
    u_if.DIN          = '0;
    u_if.VIN          = 1'b0;
    u_if.COEF_WE      = 1'b0;
    u_if.COEF_ADDR    = '0;
    u_if.COEF_DATA    = '0;
    u_if.COEF_COMMIT  = 1'b0;

    repeat (2) @(negedge CLK);
    chk("rst_rdy", u_if.RDY_IN, 0);
    chk("rst_vwin", VWIN, 0);
    chk("rst_fill", FILL_CNT, 0);
    chk("rst_tp0", tp_w[0], 0);
    chk("rst_h0", H[0], 0);
    RST_n = 1'b1;

    // IDLE: samples offered before any commit are refused
    for (int k = 0; k < 4; k++) begin
      u_if.VIN = 1'b1;
      u_if.DIN = 13'sd5;
      #1;
      chk("idle_rdy", u_if.RDY_IN, 0);
      @(negedge CLK);
      chk("idle_vwin", VWIN, 0);
    end
    u_if.VIN = 1'b0;
    chk("idle_fill", FILL_CNT, 0);
    for (int j = 0; j < TAPS; j++) begin
      chk("idle_tp", tp_w[j], 0);
      chk("idle_h", H[j], 0);
    end

    // Load shadow 1..8 then commit
    for (int i = 0; i < TAPS; i++) begin
      u_if.COEF_WE   = 1'b1;
      u_if.COEF_ADDR = 3'(i);
      u_if.COEF_DATA = 13'(i + 1);
      @(negedge CLK);
    end
    u_if.COEF_WE = 1'b0;
    chk("pre_commit_h0", H[0], 0);
    u_if.COEF_COMMIT = 1'b1;
    #1;
    chk("commit_rdy", u_if.RDY_IN, 0);
    @(negedge CLK);
    u_if.COEF_COMMIT = 1'b0;
    #1;
    chk("post_commit_rdy", u_if.RDY_IN, 1);
    for (int j = 0; j < TAPS; j++) begin
      chk("commit_h", H[j], j + 1);
    end

    // Fill with 10..80 back-to-back
    for (int k = 1; k <= TAPS; k++) begin
      push(10 * k);
      chk("fill_cnt", FILL_CNT, k);
      chk("fill_vwin", VWIN, (k == TAPS) ? 1 : 0);
    end
    for (int j = 0; j < TAPS; j++) begin
      chk("full_tp", tp_w[j], 80 - 10 * j);
    end
    push(90);
    chk("run90_vwin", VWIN, 1);
    chk("run90_tp0", tp_w[0], 90);
    chk("run90_tp7", tp_w[7], 20);
    chk("run90_fill", FILL_CNT, 8);

    // VIN pattern 1,0,0,1
    push(100);
    chk("pat_v1", VWIN, 1);
    idle_cycle();
    chk("pat_v0a", VWIN, 0);
    idle_cycle();
    chk("pat_v0b", VWIN, 0);
    push(110);
    chk("pat_v1b", VWIN, 1);
    chk("pat_tp0", tp_w[0], 110);
    chk("pat_tp1", tp_w[1], 100);
    chk("pat_tp7", tp_w[7], 40);

    // FLUSH with a competing sample
    FLUSH    = 1'b1;
    u_if.VIN = 1'b1;
    u_if.DIN = 13'sd99;
    #1;
    chk("flush_rdy", u_if.RDY_IN, 0);
    @(negedge CLK);
    FLUSH    = 1'b0;
    u_if.VIN = 1'b0;
    chk("flush_fill", FILL_CNT, 0);
    chk("flush_vwin", VWIN, 0);
    for (int j = 0; j < TAPS; j++) begin
      chk("flush_tp", tp_w[j], 0);
    end
    for (int k = 1; k <= TAPS; k++) begin
      push(k);
      chk("refill_vwin", VWIN, (k == TAPS) ? 1 : 0);
    end
    chk("refill_tp0", tp_w[0], 8);
    chk("refill_tp7", tp_w[7], 1);

    // Shadow write without commit leaves H alone
    u_if.COEF_WE   = 1'b1;
    u_if.COEF_ADDR = 3'd3;
    u_if.COEF_DATA = -13'sd5;
    @(negedge CLK);
    u_if.COEF_WE = 1'b0;
    chk("shadow_h3", H[3], 4);

    // Commit with a same-cycle write to entry 0 and a competing sample
    u_if.COEF_COMMIT = 1'b1;
    u_if.COEF_WE     = 1'b1;
    u_if.COEF_ADDR   = 3'd0;
    u_if.COEF_DATA   = 13'sd7;
    u_if.VIN         = 1'b1;
    u_if.DIN         = 13'sd55;
    #1;
    chk("cwt_rdy", u_if.RDY_IN, 0);
    @(negedge CLK);
    u_if.COEF_COMMIT = 1'b0;
    u_if.COEF_WE     = 1'b0;
    u_if.VIN         = 1'b0;
    #1;
    chk("cwt_h0", H[0], 7);
    chk("cwt_h1", H[1], 2);
    chk("cwt_h3", H[3], -5);
    chk("cwt_tp0", tp_w[0], 8);
    chk("cwt_fill", FILL_CNT, 8);
    chk("cwt_vwin", VWIN, 0);
    chk("cwt_rdy_after", u_if.RDY_IN, 1);

    // Asynchronous reset mid-stream
    push(200);
    chk("prerst_vwin", VWIN, 1);
    #2;
    RST_n = 1'b0;
    #1;
    chk("arst_vwin", VWIN, 0);
    chk("arst_fill", FILL_CNT, 0);
    chk("arst_tp0", tp_w[0], 0);
    chk("arst_h0", H[0], 0);
    chk("arst_h3", H[3], 0);
    @(negedge CLK);
    RST_n    = 1'b1;
    u_if.VIN = 1'b1;
    #1;
    chk("arst_idle_rdy", u_if.RDY_IN, 0);
    @(negedge CLK);
    u_if.VIN = 1'b0;
    chk("arst_idle_fill", FILL_CNT, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
